// File: rtl/sntrup_pkg.sv
// Shared constants and FSM state encoding for the sntrup coefficient datapath.
package sntrup_pkg;

  localparam int unsigned Q      = 4591;
  localparam int unsigned P      = 761;
  localparam int unsigned COEF_W = 13;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned Q_HALF = 2295;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/coef_skid_fifo.sv
// Two-entry registered FIFO; the head entry always sits in a register, never bypassed.
module coef_skid_fifo #(
  parameter int unsigned W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (i_push) begin
            r_head <= i_data;
            r_cnt  <= 2'd1;
          end
        end
        2'd1: begin
          if (i_push && i_pop) begin
            r_head <= i_data;
          end else if (i_push) begin
            r_tail <= i_data;
            r_cnt  <= 2'd2;
          end else if (i_pop) begin
            r_cnt  <= 2'd0;
          end
        end
        default: begin
          // Full: a pop promotes the tail; a simultaneous push refills it.
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) r_tail <= i_data;
            else        r_cnt  <= 2'd1;
          end
        end
      endcase
    end
  end

  assign o_data  = r_head;
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/poly_coef_reader.sv
// Streams a wrap-around range of coefficient RAM words as valid/ready beats,
// optionally mapping each value to its centred signed representative mod Q.
module poly_coef_reader #(
  parameter int unsigned COEF_W = 13,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned Q      = 4591
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              center_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [COEF_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [COEF_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              range_err
);

  import sntrup_pkg::*;

  localparam int unsigned QH = (Q - 1) / 2;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_rem;
  logic              r_center;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_full;
  logic              w_empty;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_over;
  logic              w_last;
  logic [COEF_W-1:0] w_proc;
  logic [COEF_W:0]   w_head;

  assign w_valid = !w_empty;
  assign w_pop   = w_valid && m_ready;
  assign w_push  = (r_state == ST_RUN) && (!w_full || w_pop);
  assign w_last  = (r_rem == ADDR_W'(1));
  assign w_over  = (rd_data >= COEF_W'(Q));

  // Out-of-range values pass through untouched; upper half maps to v - Q.
  always_comb begin
    w_proc = rd_data;
    if (!w_over && r_center && (rd_data > COEF_W'(QH))) begin
      w_proc = rd_data - COEF_W'(Q);
    end
  end

  coef_skid_fifo #(
    .W(COEF_W + 1)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_data ({w_last, w_proc}),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_rem    <= '0;
      r_center <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ptr    <= base_addr;
            r_rem    <= length;
            r_center <= center_en;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= (length == '0) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_push) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            r_rem <= r_rem - ADDR_W'(1);
            if (w_over) r_err   <= 1'b1;
            if (w_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_addr   = r_ptr;
  assign m_valid   = w_valid;
  assign m_data    = w_head[COEF_W-1:0];
  assign m_last    = w_head[COEF_W] && w_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign range_err = r_err;

endmodule

// File: tb/tb_poly_coef_reader.sv
// Directed bench for poly_coef_reader with a RAM model and a beat scoreboard.
module tb_poly_coef_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] base_addr;
  logic [10:0] length;
  logic        center_en;
  logic [10:0] rd_addr;
  logic [12:0] rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [12:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;
  logic        range_err;

  logic [12:0] mem [0:2047];
  logic [13:0] exp_q [$];

  int checks = 0;
  int failures = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int ncyc = 0;
  int last_cyc = 0;
  int done_cyc = 0;
  int rmode = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  bit          prev_stall = 1'b0;
  bit          prev_busy = 1'b0;
  logic [13:0] prev_beat = '0;
  logic [10:0] prev_addr = '0;

  assign rd_data = mem[rd_addr];

  poly_coef_reader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .center_en(center_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done),
    .range_err(range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic logic [12:0] proc(input logic [12:0] v, input bit cen);
    if (v >= 13'd4591) return v;
    if (cen && (v > 13'd2295)) return 13'(int'(v) + 8192 - 4591);
    return v;
  endfunction

  task automatic push_exp(input int base, input int len, input bit cen);
    logic [10:0] a;
    for (int i = 0; i < len; i++) begin
      a = 11'(base + i);
      exp_q.push_back({(i == len - 1), proc(mem[a], cen)});
    end
  endtask

  // Called at posedge+1; returns one cycle later, just after the start edge.
  task automatic start_cmd(input int base, input int len, input bit cen);
    start     = 1'b1;
    base_addr = 11'(base);
    length    = 11'(len);
    center_en = cen;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      m_ready = (rmode == 0) ? 1'b1 : pat[i % 6];
      @(posedge clk); #1;
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(ok), 32'd1);
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Beat scoreboard, stall stability, done and address-step monitor.
  always @(negedge clk) begin
    logic [13:0] e;
    ncyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_hold", 32'({m_last, m_data}), 32'(prev_beat));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'({m_last, m_data}), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(m_data), 32'(e[12:0]));
          chk("beat_last", 32'(m_last), 32'(e[13]));
        end
        beat_cnt++;
        if (m_last) last_cyc = ncyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = ncyc;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      if (prev_busy && busy && (rd_addr != prev_addr))
        chk("rd_addr_step", 32'(rd_addr), 32'(11'(prev_addr + 11'd1)));
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_last, m_data};
      prev_busy  = busy;
      prev_addr  = rd_addr;
    end
  end

  initial begin
    int b0;
    int d0;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    center_en = 1'b0;
    m_ready   = 1'b1;
    for (int i = 0; i < 2048; i++) mem[i] = 13'(i % 4591);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(range_err), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full read, no backpressure
    rmode = 0;
    push_exp(0, 761, 1'b0);
    b0 = beat_cnt;
    start_cmd(0, 761, 1'b0);
    chk("lat_e0_valid", 32'(m_valid), 32'd0);
    chk("lat_e0_busy", 32'(busy), 32'd1);
    chk("lat_e0_addr", 32'(rd_addr), 32'd0);
    @(posedge clk); #1;
    chk("lat_e1_valid", 32'(m_valid), 32'd1);
    wait_done(2000);
    chk("full_beats", 32'(beat_cnt - b0), 32'd761);
    chk("full_done_after_last", 32'(done_cyc - last_cyc), 32'd2);
    chk("full_err", 32'(range_err), 32'd0);

    // Centring
    mem[0] = 13'd2295;
    mem[1] = 13'd2296;
    mem[2] = 13'd4590;
    mem[3] = 13'd0;
    exp_q.push_back({1'b0, 13'h08F7});
    exp_q.push_back({1'b0, 13'h1709});
    exp_q.push_back({1'b0, 13'h1FFF});
    exp_q.push_back({1'b1, 13'h0000});
    b0 = beat_cnt;
    start_cmd(0, 4, 1'b1);
    wait_done(50);
    chk("cent_beats", 32'(beat_cnt - b0), 32'd4);

    // Backpressure, centred random data
    for (int i = 100; i < 132; i++) mem[i] = 13'($urandom_range(0, 4590));
    rmode = 1;
    push_exp(100, 32, 1'b1);
    b0 = beat_cnt;
    start_cmd(100, 32, 1'b1);
    wait_done(400);
    chk("bp_beats", 32'(beat_cnt - b0), 32'd32);
    rmode = 0;

    // Address wrap
    push_exp(2040, 16, 1'b0);
    b0 = beat_cnt;
    start_cmd(2040, 16, 1'b0);
    chk("wrap_first_addr", 32'(rd_addr), 32'd2040);
    wait_done(100);
    chk("wrap_beats", 32'(beat_cnt - b0), 32'd16);
    chk("wrap_end_addr", 32'(rd_addr), 32'd8);

    // Zero length
    b0 = beat_cnt;
    d0 = done_cnt;
    start_cmd(0, 0, 1'b0);
    chk("zl_busy", 32'(busy), 32'd1);
    chk("zl_done_early", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("zl_done", 32'(done), 32'd1);
    chk("zl_valid", 32'(m_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("zl_done_once", 32'(done_cnt - d0), 32'd1);
    chk("zl_no_beats", 32'(beat_cnt - b0), 32'd0);

    // Second start during a run is ignored
    for (int i = 0; i < 10; i++) mem[i] = 13'(1000 + i);
    push_exp(0, 10, 1'b0);
    b0 = beat_cnt;
    start_cmd(0, 10, 1'b0);
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start_cmd(500, 20, 1'b0);
    wait_done(100);
    chk("ign_beats", 32'(beat_cnt - b0), 32'd10);
    chk("ign_end_addr", 32'(rd_addr), 32'd10);

    // Range error then reset mid-command
    mem[3] = 13'd5000;
    push_exp(0, 8, 1'b0);
    b0 = beat_cnt;
    start_cmd(0, 8, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (beat_cnt - b0 >= 5) break;
      @(posedge clk); #1;
    end
    chk("re_beats5", 32'(beat_cnt - b0 >= 5), 32'd1);
    chk("re_err", 32'(range_err), 32'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_last", 32'(m_last), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(range_err), 32'd0);
    chk("mid_rst_addr", 32'(rd_addr), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem[3] = 13'd3;
    push_exp(0, 8, 1'b0);
    b0 = beat_cnt;
    start_cmd(0, 8, 1'b0);
    wait_done(100);
    chk("post_rst_beats", 32'(beat_cnt - b0), 32'd8);
    chk("post_rst_err", 32'(range_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
